// File: rtl/dir_input_conditioner_if.sv
// Bundle of key, tick and committed-direction signals between the key front end and the game core.
// Handshake: no valid/ready; tick is a one-cycle strobe, and dir/pending/reject are level/pulse outputs updated only on clk edges.
interface dir_input_conditioner_if;
    logic [3:0] key_n;
    logic       tick;
    logic [2:0] dir;
    logic       pending;
    logic       reject;

    modport master (
        output key_n,
        output tick,
        input  dir,
        input  pending,
        input  reject
    );

    modport slave (
        input  key_n,
        input  tick,
        output dir,
        output pending,
        output reject
    );
endinterface

// File: rtl/dir_input_conditioner.sv
// Synchronizes and debounces four active-low direction keys, drops 180-degree reversals,
// and commits at most one stored direction request per game tick.
module dir_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    dir_input_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [3:0]       r_stable_q;
    logic [CNT_W-1:0] r_cnt [4];

    logic [2:0]       r_dir;
    logic [2:0]       r_req;
    logic             r_pending;
    logic             r_reject;

    logic [3:0]       w_press;
    logic [2:0]       w_eff;
    logic [2:0]       w_form;
    logic             w_hit;
    logic             w_reversal;
    logic             w_accept;
    logic             w_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= bus.key_n;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only advances while the synchronized key disagrees with the
    // debounced level, so it can never exceed CNT_MAX and never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable   <= 4'hF;
            r_stable_q <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable_q <= r_stable;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is the cycle after a debounced level falls; releases are ignored.
    assign w_press  = r_stable_q & ~r_stable;
    assign w_commit = bus.tick && r_pending;

    always_comb begin
        w_eff  = w_commit ? r_req : r_dir;
        w_form = w_eff;
        w_hit  = 1'b1;
        if (w_press[3]) begin
            w_form = {2'b10, w_eff[0]};
        end else if (w_press[2]) begin
            w_form = {2'b11, w_eff[0]};
        end else if (w_press[1]) begin
            w_form = {1'b0, w_eff[1], 1'b0};
        end else if (w_press[0]) begin
            w_form = {1'b0, w_eff[1], 1'b1};
        end else begin
            w_hit = 1'b0;
        end
        w_reversal = (w_form[2] == w_eff[2]) &&
                     (w_form[2] ? (w_form[1] != w_eff[1]) : (w_form[0] != w_eff[0]));
        w_accept   = w_hit && !w_reversal;
    end

    // A press in the tick cycle is judged against the request being committed,
    // so it may legitimately refill pending on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir     <= 3'b000;
            r_req     <= 3'b000;
            r_pending <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            r_reject <= w_hit && w_reversal;
            if (w_commit) begin
                r_dir <= r_req;
            end
            if (w_accept) begin
                r_req     <= w_form;
                r_pending <= 1'b1;
            end else if (bus.tick) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.dir     = r_dir;
    assign bus.pending = r_pending;
    assign bus.reject  = r_reject;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Randomized and directed bench for dir_input_conditioner with a key-history reference model
// and an expected-output queue drained by an independent monitor.
module tb_dir_input_conditioner;

    localparam int DB = 4;

    logic clk;
    logic reset;

    dir_input_conditioner_if bus ();

    dir_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];

    // Reference model state: history of sampled keys since reset, plus game state.
    logic [3:0] m_hist[$];
    logic [3:0] m_stable;
    int         m_last_flip[4];
    int         m_n;
    logic [3:0] m_press;
    logic [2:0] m_dir;
    logic [2:0] m_req;
    logic       m_pend;

    function automatic logic [3:0] sync_at(int e);
        if (e >= 2) return m_hist[e-2];
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_stable = 4'hF;
        for (int i = 0; i < 4; i++) m_last_flip[i] = -1;
        m_n     = 0;
        m_press = 4'h0;
        m_dir   = 3'b000;
        m_req   = 3'b000;
        m_pend  = 1'b0;
    endtask

    // Key indices: 3 left, 2 right, 1 up, 0 down. Opposite keys differ only in bit 0.
    task automatic model_edge(input logic [3:0] k, input logic t);
        logic [2:0] eff;
        int         heading;
        int         winner;
        logic       rej;
        logic [3:0] new_press;
        logic [3:0] s;
        logic       flip;
        m_hist.push_back(k);
        eff     = (t && m_pend) ? m_req : m_dir;
        heading = eff[2] ? (eff[1] ? 2 : 3) : (eff[0] ? 0 : 1);
        winner  = -1;
        for (int i = 0; i < 4; i++) if (m_press[i]) winner = i;
        rej = 1'b0;
        if (t && m_pend) begin
            m_dir  = m_req;
            m_pend = 1'b0;
        end
        if (winner >= 0) begin
            if (winner == (heading ^ 1)) begin
                rej = 1'b1;
            end else begin
                case (winner)
                    3:       m_req = {2'b10, eff[0]};
                    2:       m_req = {2'b11, eff[0]};
                    1:       m_req = {1'b0, eff[1], 1'b0};
                    default: m_req = {1'b0, eff[1], 1'b1};
                endcase
                m_pend = 1'b1;
            end
        end
        // A level flips once DB consecutive synchronized samples since the last flip disagree with it.
        new_press = 4'h0;
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++) begin
                s = sync_at(m_n - j);
                if ((m_n - j) <= m_last_flip[i] || (m_n - j) < 0 || s[i] == m_stable[i]) flip = 1'b0;
            end
            if (flip) begin
                m_stable[i]    = ~m_stable[i];
                m_last_flip[i] = m_n;
                if (m_stable[i] == 1'b0) new_press[i] = 1'b1;
            end
        end
        m_press = new_press;
        m_n++;
        exp_q.push_back({m_dir, m_pend, rej});
    endtask

    task automatic step(input logic [3:0] k, input logic t);
        @(negedge clk);
        bus.key_n = k;
        bus.tick  = t;
        model_edge(k, t);
    endtask

    task automatic hold(input logic [3:0] k, input logic t, input int n);
        for (int i = 0; i < n; i++) step(k, t);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got dir=%b pending=%b reject=%b, expected dir=%b pending=%b reject=%b",
                     name, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_after_edge(input string name, input logic [4:0] exp);
        @(posedge clk);
        #1;
        check(name, {bus.dir, bus.pending, bus.reject}, exp);
    endtask

    task automatic release_reset(input logic [3:0] k);
        @(negedge clk);
        reset     = 1'b0;
        bus.key_n = k;
        bus.tick  = 1'b0;
        model_reset();
        model_edge(k, 1'b0);
    endtask

    task automatic apply_reset(input logic [3:0] k);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {bus.dir, bus.pending, bus.reject}, 5'b000_0_0);
        bus.key_n = k;
        bus.tick  = 1'b0;
        repeat (2) @(negedge clk);
        release_reset(k);
    endtask

    logic [4:0] mon_got;
    logic [4:0] mon_exp;
    int         mon_cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                mon_got = {bus.dir, bus.pending, bus.reject};
                mon_exp = exp_q.pop_front();
                checks++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL model_cycle_%0d: got dir=%b pending=%b reject=%b, expected dir=%b pending=%b reject=%b",
                             mon_cyc, mon_got[4:2], mon_got[1], mon_got[0], mon_exp[4:2], mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] pat;
        logic [3:0] a;
        logic [3:0] b;
        reset     = 1'b1;
        bus.key_n = 4'hF;
        bus.tick  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", {bus.dir, bus.pending, bus.reject}, 5'b000_0_0);
        release_reset(4'hF);

        // Idle keys with regular ticks.
        for (int i = 0; i < 20; i++) step(4'hF, (i % 3) == 0);
        check_after_edge("idle_ticks", 5'b000_0_0);

        // Short glitch on right, then a held press and its commit.
        hold(4'b1011, 1'b0, 3);
        hold(4'b1111, 1'b0, 6);
        check_after_edge("glitch_ignored", 5'b000_0_0);
        hold(4'b1011, 1'b0, 6);
        check_after_edge("latency_not_yet", 5'b000_0_0);
        step(4'b1011, 1'b0);
        check_after_edge("latency_seven", 5'b000_1_0);
        step(4'b1011, 1'b1);
        check_after_edge("commit_right", 5'b110_0_0);
        hold(4'b1111, 1'b0, 10);

        // Reversal against right.
        hold(4'b0111, 1'b0, 6);
        step(4'b0111, 1'b0);
        check_after_edge("reject_pulse", 5'b110_0_1);
        step(4'b0111, 1'b0);
        check_after_edge("reject_one_cycle", 5'b110_0_0);
        hold(4'b1111, 1'b0, 10);
        step(4'b1111, 1'b1);
        check_after_edge("reject_dir_held", 5'b110_0_0);

        // Right then down before any tick, judged against up.
        apply_reset(4'hF);
        hold(4'b1011, 1'b0, 8);
        hold(4'b1111, 1'b0, 8);
        hold(4'b1110, 1'b0, 8);
        hold(4'b1111, 1'b0, 8);
        step(4'b1111, 1'b1);
        hold(4'b1111, 1'b0, 3);

        // Simultaneous left and up: left has priority.
        apply_reset(4'hF);
        hold(4'b0101, 1'b0, 8);
        hold(4'b1111, 1'b0, 8);
        step(4'b1111, 1'b1);
        check_after_edge("priority_left", 5'b100_0_0);

        // Tick coinciding with an accepted down press.
        apply_reset(4'hF);
        hold(4'b1011, 1'b0, 8);
        hold(4'b1111, 1'b0, 8);
        hold(4'b1110, 1'b0, 6);
        step(4'b1110, 1'b1);
        check_after_edge("tick_with_press", 5'b110_1_0);
        step(4'b1110, 1'b1);
        check_after_edge("second_commit", 5'b011_0_0);

        // Reset mid-debounce with up held through reset.
        hold(4'b1101, 1'b0, 2);
        apply_reset(4'b1101);
        hold(4'b1101, 1'b0, 10);
        step(4'b1101, 1'b1);
        hold(4'b1111, 1'b0, 8);

        // Randomized key patterns and ticks.
        for (int seg = 0; seg < 60; seg++) begin
            a   = 4'h1 << $urandom_range(0, 3);
            b   = 4'h1 << $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0, 1:    pat = 4'hF;
                2, 3:    pat = ~(a | b);
                default: pat = ~a;
            endcase
            for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
                step(pat, $urandom_range(0, 5) == 0);
            end
            if (seg == 30) apply_reset(pat);
        end
        hold(4'hF, 1'b1, 4);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
